// File: rtl/button_conditioner.sv
// Four-button front end: 2-flop synchronizers, per-button debounce,
// press detection, auto-repeat FSM, and opposite-direction arbitration
// on the step outputs consumed by the physics stage.
//
// FSM states (per button)
//   state    | meaning
//   S_IDLE   | debounced level is 0, timer parked at 0
//   S_DELAY  | held, counting towards the first auto-repeat
//   S_REPEAT | held, emitting a repeat pulse every REPEAT_PERIOD cycles
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 12500000,
   parameter int REPEAT_PERIOD   = 2500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [3:0] btn_level,
   output logic [3:0] btn_press,
   output logic [3:0] btn_step
);

   localparam int CW    = $clog2(DEBOUNCE_CYCLES);
   localparam int T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TW    = $clog2(T_MAX);

   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DELAY  = 2'd1,
      S_REPEAT = 2'd2
   } state_t;

   logic [3:0] w_raw;
   logic [3:0] r_sync1;
   logic [3:0] r_sync2;
   logic [3:0] w_level;
   logic [3:0] w_press;
   logic [3:0] w_pre_step;
   logic       w_mask_lr;
   logic       w_mask_ud;

   assign w_raw = {btn_down, btn_up, btn_right, btn_left};

   // Two-flop synchronizer; the only consumer of the raw pins.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_btn
      logic [CW-1:0] r_cnt;
      logic          r_level;
      logic          r_press;
      logic          r_rep;
      logic [TW-1:0] r_timer;
      logic [TW-1:0] w_timer_nxt;
      state_t        r_state;
      state_t        w_state_nxt;
      logic          w_differ;
      logic          w_flip;
      logic          w_rise;
      logic          w_fall;
      logic          w_rep_fire;

      assign w_differ = (r_sync2[g] != r_level);
      assign w_flip   = w_differ && (r_cnt == CNT_LAST);
      assign w_rise   = w_flip && !r_level;
      assign w_fall   = w_flip && r_level;

      // Debounce counter and level; press pulse registered alongside the rise.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
         end else begin
            r_press <= w_rise;
            if (!w_differ) begin
               r_cnt <= '0;
            end else if (w_flip) begin
               r_cnt   <= '0;
               r_level <= ~r_level;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end

      // Repeat FSM state register, timer and registered repeat pulse.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_rep   <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_rep   <= w_rep_fire;
         end
      end

      // Next-state and timer update; a falling level always wins.
      always_comb begin
         w_state_nxt = r_state;
         w_timer_nxt = r_timer;
         case (r_state)
            S_IDLE: begin
               w_timer_nxt = '0;
               if (w_rise) w_state_nxt = S_DELAY;
            end
            S_DELAY: begin
               if (w_fall) begin
                  w_state_nxt = S_IDLE;
                  w_timer_nxt = '0;
               end else if (r_timer == DLY_LAST) begin
                  w_state_nxt = S_REPEAT;
                  w_timer_nxt = '0;
               end else begin
                  w_timer_nxt = r_timer + TW'(1);
               end
            end
            S_REPEAT: begin
               if (w_fall) begin
                  w_state_nxt = S_IDLE;
                  w_timer_nxt = '0;
               end else if (r_timer == PER_LAST) begin
                  w_timer_nxt = '0;
               end else begin
                  w_timer_nxt = r_timer + TW'(1);
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_timer_nxt = '0;
            end
         endcase
      end

      // Repeat pulse request; suppressed on the edge the level falls.
      always_comb begin
         w_rep_fire = 1'b0;
         if (!w_fall) begin
            if (r_state == S_DELAY && r_timer == DLY_LAST)
               w_rep_fire = 1'b1;
            else if (r_state == S_REPEAT && r_timer == PER_LAST)
               w_rep_fire = 1'b1;
         end
      end

      assign w_level[g]    = r_level;
      assign w_press[g]    = r_press;
      assign w_pre_step[g] = r_press | r_rep;
   end

   assign w_mask_lr = w_level[0] & w_level[1];
   assign w_mask_ud = w_level[2] & w_level[3];

   assign btn_level = w_level;
   assign btn_press = w_press;
   assign btn_step  = w_pre_step & ~{w_mask_ud, w_mask_ud, w_mask_lr, w_mask_lr};

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small timing parameters.
// Expected outputs come from closed-form press/release timing and are
// queued before each clock edge, then popped and checked after it.
module tb_button_conditioner;

   localparam int DEB  = 4;
   localparam int RD   = 10;
   localparam int RP   = 3;
   localparam int NONE = 1 << 30;

   typedef struct packed {
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] stp;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] raw;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [3:0] btn_step;

   exp_t sb_q[$];
   int   h[4];
   int   r[4];
   int   e;
   int   n_pass;
   int   n_total;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_left (raw[0]),
      .btn_right(raw[1]),
      .btn_up   (raw[2]),
      .btn_down (raw[3]),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .btn_step (btn_step)
   );

   always #5 clk = ~clk;

   // Outputs after edge eg for a button held from h (first sampling edge)
   // and released at r (first sampling edge of the low level).
   function automatic exp_t model(input int eg);
      exp_t       x;
      logic [3:0] pre;
      int         rise;
      int         first_rep;
      x   = '0;
      pre = '0;
      for (int b = 0; b < 4; b++) begin
         if (h[b] != NONE) begin
            rise      = h[b] + DEB + 1;
            first_rep = rise + RD;
            x.lvl[b]  = (eg >= rise) && (eg < r[b] + DEB + 1);
            x.prs[b]  = (eg == rise);
            pre[b]    = x.prs[b] ||
                        ((eg >= first_rep) && ((eg - first_rep) % RP == 0) &&
                         (eg < r[b] + DEB + 1));
         end
      end
      x.stp = pre & ~{x.lvl[2] & x.lvl[3], x.lvl[2] & x.lvl[3],
                      x.lvl[0] & x.lvl[1], x.lvl[0] & x.lvl[1]};
      return x;
   endfunction

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
      n_total++;
      assert (got === want) n_pass++;
      else $error("FAIL %s edge=%0d got=%b expected=%b", tag, e, got, want);
   endtask

   task automatic tick(input bit rst_now);
      exp_t ex;
      exp_t want;
      reset = rst_now;
      ex = rst_now ? exp_t'('0) : model(e + 1);
      sb_q.push_back(ex);
      @(posedge clk);
      #1;
      e++;
      want = sb_q.pop_front();
      check("level", btn_level, want.lvl);
      check("press", btn_press, want.prs);
      check("step",  btn_step,  want.stp);
      if (rst_now) begin
         for (int b = 0; b < 4; b++) begin
            h[b] = raw[b] ? e + 1 : NONE;
            r[b] = NONE;
         end
      end
      reset = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick(1'b0);
   endtask

   task automatic press(input int b);
      raw[b] = 1'b1;
      h[b]   = e + 1;
      r[b]   = NONE;
   endtask

   task automatic release_btn(input int b);
      raw[b] = 1'b0;
      r[b]   = e + 1;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      e       = 0;
      raw     = '0;
      reset   = 1'b1;
      for (int b = 0; b < 4; b++) begin
         h[b] = NONE;
         r[b] = NONE;
      end
      #2;

      // Reset state, then idle.
      tick(1'b1);
      tick(1'b1);
      ticks(3);

      // Left press and hold into auto-repeat.
      press(0);
      ticks(22);

      // Right pressed while left repeats: both step bits masked.
      press(1);
      ticks(14);

      // Right released: left resumes on its original schedule.
      release_btn(1);
      ticks(14);
      release_btn(0);
      ticks(10);

      // Short glitch on up: no level, no pulses.
      raw[2] = 1'b1;
      ticks(3);
      raw[2] = 1'b0;
      ticks(8);

      // Down held 40 cycles; the release lands on a repeat expiry.
      press(3);
      ticks(40);
      release_btn(3);
      ticks(12);

      // Right held into repeat, one-cycle reset, held through release.
      press(1);
      ticks(20);
      tick(1'b1);
      ticks(22);
      release_btn(1);
      ticks(10);

      // Down pressed again from idle: fresh timing after the coincident release.
      press(3);
      ticks(18);
      release_btn(3);
      ticks(8);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
